// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS instruction requests and
// streams the resulting words into instruction memory, one per transfer.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   finish,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_kind,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic [4:0]             rd,
    input  logic [4:0]             shamt,
    input  logic [5:0]             funct,
    input  logic [15:0]            imm,
    input  logic [25:0]            target,
    output logic                   imem_we,
    output logic [31:0]            imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   full,
    output logic                   err
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic [31:0]     enc;
    logic            legal;
    logic            xfer;
    logic            wr;
    logic            last;

    // Encode the presented request; kinds 6/7 have no encoding
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (req_kind)
            3'd0:    enc = {6'b100011, rs, rt, imm};
            3'd1:    enc = {6'b101011, rs, rt, imm};
            3'd2:    enc = {6'b000000, rs, rt, rd, shamt, funct};
            3'd3:    enc = {6'b001000, rs, rt, imm};
            3'd4:    enc = {6'b000100, rs, rt, imm};
            3'd5:    enc = {6'b000010, target};
            default: legal = 1'b0;
        endcase
    end

    assign xfer = req_valid && req_ready;
    assign wr   = xfer && legal;
    assign last = (count_q == CW'(DEPTH - 1));

    // Session state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Session transitions; start always (re)opens, finish wins over filling
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (start)          state_d = S_ACTIVE;
                else if (finish)    state_d = S_IDLE;
                else if (wr && last) state_d = S_FULL;
            end
            S_FULL: begin
                if (start)       state_d = S_ACTIVE;
                else if (finish) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the session state
    always_comb begin
        req_ready = (state_q == S_ACTIVE) && !start;
        busy      = (state_q != S_IDLE);
    end

    // Datapath next state: registered write port, word counter, error flag
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        addr_d  = addr_q;
        we_d    = wr;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wr) begin
            waddr_d = addr_q;
            wdata_d = enc;
            addr_d  = addr_q + 32'd4;
            count_d = count_q + CW'(1);
        end
        if (xfer && !legal) begin
            err_d = 1'b1;
        end
        if (start) begin
            count_d = '0;
            err_d   = 1'b0;
            addr_d  = BASE_ADDR;
        end
    end

    // Datapath registers; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus random checks of the encoder
// loader against a transaction-level model.
module tb_instr_encoder_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        finish;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        busy;
    logic        full;
    logic        err;

    int n_chk;
    int n_pass;

    // model: 0 idle, 1 loading, 2 full
    int          ms;
    int          m_count;
    bit          m_err;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    instr_encoder_loader #(
        .BASE_ADDR(BASE),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .finish(finish),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_kind(req_kind),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .shamt(shamt),
        .funct(funct),
        .imm(imm),
        .target(target),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .count(count),
        .busy(busy),
        .full(full),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] enc_ref();
        longint w;
        longint op;
        case (int'(req_kind))
            0: op = 35;
            1: op = 43;
            3: op = 8;
            4: op = 4;
            5: op = 2;
            default: op = 0;
        endcase
        if (req_kind == 3'd5)
            w = op * 64'd67108864 + longint'(target);
        else if (req_kind == 3'd2)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536
              + longint'(rd) * 2048 + longint'(shamt) * 64
              + longint'(funct);
        else
            w = op * 64'd67108864 + longint'(rs) * 2097152
              + longint'(rt) * 65536 + longint'(imm);
        return w[31:0];
    endfunction

    task automatic model_reset();
        ms      = 0;
        m_count = 0;
        m_err   = 0;
        m_we    = 0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic check_outs();
        check("we", 32'(imem_we), 32'(m_we));
        check("addr", imem_addr, m_addr);
        check("wdata", imem_wdata, m_wdata);
        check("count", 32'(count), 32'(m_count));
        check("busy", 32'(busy), 32'(ms != 0));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("err", 32'(err), 32'(m_err));
    endtask

    // Inputs already driven just after a negedge; advance one cycle
    task automatic step();
        bit rdy;
        bit x;
        #1;
        rdy = (ms == 1) && !start;
        check("ready", 32'(req_ready), 32'(rdy));
        x = req_valid && rdy;
        m_we = 0;
        if (x) begin
            if (req_kind <= 3'd5) begin
                m_we    = 1;
                m_addr  = BASE + 32'(4 * m_count);
                m_wdata = enc_ref();
                m_count = m_count + 1;
            end else begin
                m_err = 1;
            end
        end
        if (start) begin
            ms      = 1;
            m_count = 0;
            m_err   = 0;
        end else if (ms == 1 && finish) begin
            ms = 0;
        end else if (ms == 1 && m_count == DEPTH) begin
            ms = 2;
        end else if (ms == 2 && finish) begin
            ms = 0;
        end
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic drive(int k, int a_rs, int a_rt, int a_rd, int a_sh,
                         int a_fn, int a_imm, int a_tgt);
        start     = 1'b0;
        finish    = 1'b0;
        req_valid = 1'b1;
        req_kind  = 3'(k);
        rs        = 5'(a_rs);
        rt        = 5'(a_rt);
        rd        = 5'(a_rd);
        shamt     = 5'(a_sh);
        funct     = 6'(a_fn);
        imm       = 16'(a_imm);
        target    = 26'(a_tgt);
    endtask

    task automatic pulse_start();
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        req_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // request while idle is not accepted
        drive(0, 16, 8, 0, 0, 0, 4, 0);
        step();

        // single lw
        pulse_start();
        drive(0, 16, 8, 0, 0, 0, 4, 0);
        step();
        check("lw_word", imem_wdata, 32'h8E08_0004);
        check("lw_addr", imem_addr, 32'h0);
        check("lw_cnt", 32'(count), 32'd1);
        idle_in();
        step();

        // back-to-back add then sw
        pulse_start();
        drive(2, 16, 17, 18, 0, 'h20, 0, 0);
        step();
        check("add_word", imem_wdata, 32'h0211_9020);
        drive(1, 16, 8, 0, 0, 0, 8, 0);
        step();
        check("sw_word", imem_wdata, 32'hAE08_0008);
        check("sw_addr", imem_addr, 32'h4);
        check("sw_we", 32'(imem_we), 32'd1);
        idle_in();
        step();

        // addi, beq, j
        pulse_start();
        drive(3, 0, 8, 0, 0, 0, 5, 0);
        step();
        check("addi_word", imem_wdata, 32'h2008_0005);
        drive(4, 8, 9, 0, 0, 0, 'hFFFF, 0);
        step();
        check("beq_word", imem_wdata, 32'h1109_FFFF);
        drive(5, 0, 0, 0, 0, 0, 0, 'h0100000);
        step();
        check("j_word", imem_wdata, 32'h0810_0000);
        check("j_addr", imem_addr, 32'h8);
        idle_in();
        step();

        // illegal kind sets sticky err, cleared by start
        drive(6, 1, 2, 3, 4, 5, 6, 7);
        step();
        check("ill_err", 32'(err), 32'd1);
        check("ill_we", 32'(imem_we), 32'd0);
        idle_in();
        step();
        pulse_start();
        check("err_clr", 32'(err), 32'd0);

        // fill to DEPTH, fifth request refused
        for (int i = 0; i < 5; i++) begin
            drive(3, 0, i, 0, 0, 0, i, 0);
            step();
        end
        check("full_set", 32'(full), 32'd1);
        check("full_rdy", 32'(req_ready), 32'd0);
        check("full_last", imem_addr, 32'hC);
        idle_in();
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("fin_busy", 32'(busy), 32'd0);

        // reset right after a transfer discards the pending write
        pulse_start();
        drive(0, 16, 8, 0, 0, 0, 4, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_data", imem_wdata, 32'd0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        step();

        // random traffic
        for (int c = 0; c < 600; c++) begin
            start     = ($urandom_range(0, 15) == 0);
            finish    = ($urandom_range(0, 19) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_kind  = 3'($urandom_range(0, 7));
            rs        = 5'($urandom);
            rt        = 5'($urandom);
            rd        = 5'($urandom);
            shamt     = 5'($urandom);
            funct     = 6'($urandom);
            imm       = 16'($urandom);
            target    = 26'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
